pwm_audio_out: RTL and testbench
================================

Name: pwm_audio_out

Overview:
- Downstream sink stage for the state-variable filter's 16-bit signed sample stream; consumes the same valid/ready handshake.
- Converts each sample to a PWM_BITS-bit duty cycle and emits a 1-bit PWM audio output.
- Each sample is held for REPEAT PWM periods.
- Single-entry input buffer decouples the upstream filter from the PWM frame timing; underruns are flagged and the last sample is repeated.

Parameters:
- PWM_BITS, 8, duty resolution; PWM period = 2^PWM_BITS clocks; legal range 4..12.
- REPEAT, 4, PWM periods per sample (frame length = REPEAT*2^PWM_BITS clocks); must be ≥1.

Ports:
- clk  input  1  system clock.
- reset  input  1  one clock; reset is synchronous and active-low (reset==0 resets on the rising edge of clk).
- tvalid_slave  input  1  upstream sample valid.
- tready_slave  output  1  registered; block can accept a sample.
- tdata_slave  input  16  signed two's-complement sample.
- pwm_out  output  1  PWM audio bit.
- underrun  output  1  one-cycle pulse at a frame boundary with no pending sample.
- active  output  1  high while in RUN.

Behaviour:
- Reset (reset==0): state=IDLE, tready_slave=0, pwm_out=0, underrun=0, active=0, pending_valid=0, duty=0, period counter=0, repeat counter=0, error residue=0.
  - Reset mid-frame takes effect on the next edge; the pending sample is discarded.
- Transfer = tvalid_slave & tready_slave.
  - Each transfer writes the pending register and sets pending_valid on the next edge.
  - tready_slave <= ~pending_valid_next, so tready drops the cycle after an accept.
- Conversion: offset = tdata_slave ^ 16'h8000 (unsigned). duty = offset[15 -: PWM_BITS].
- FSM:
  - IDLE: first cycle after reset release sets tready_slave=1. pwm_out=0, counters held at 0. When pending_valid=1: load duty from pending, clear pending_valid, counters=0, go to RUN.
  - RUN: period counter increments every clock and wraps at 2^PWM_BITS-1. On each wrap the repeat counter increments, wrapping at REPEAT-1. Frame boundary = both counters at their maximum.
    - At a boundary with pending_valid=1: load duty, clear pending_valid.
    - At a boundary with pending_valid=0: keep duty, pulse underrun for that one cycle, stay in RUN.
- pwm_out = active & (period counter < duty), decoded from registered state.
  - duty=0: constantly low.
  - duty=2^PWM_BITS-1: high for all but one cycle per period.
- Latency: transfer in cycle t → pending_valid in t+1 → RUN with duty loaded and count 0 in t+2. pwm_out first reflects the sample in t+2.
- Simultaneous events:
  - A transfer and a frame-boundary load cannot collide: tready=0 whenever pending_valid=1.
  - A transfer in the boundary cycle with pending_valid=0 lands in pending. The underrun still pulses and the sample is used at the next boundary.
- Steady-state throughput: one sample per REPEAT*2^PWM_BITS clocks. Upstream is back-pressured via tready_slave.

Optional Feature:
- NOISE_SHAPE_EN defined: first-order error feedback applied at each duty load.
  - sum = offset + residue (17-bit), saturated to 16'hFFFF.
  - duty = sum[15 -: PWM_BITS]; residue <= sum[15-PWM_BITS:0].
  - Residue is cleared by reset; it is not cleared by underrun. On underrun the duty is held, with no re-accumulation.
- Undefined: plain truncation; no residue register is present.

Decomposition:
- Package sv_audio_pkg:
  - SAMPLE_W=16 and the offset-binary constant 16'h8000.
  - FSM state encoding (IDLE=0, RUN=1).
  - The PWM_BITS and REPEAT legal-range constants.
- One sub-module, pwm_duty_quantizer: combinational offset conversion, truncation or noise-shape sum, saturation. The residue register stays in the parent.

Test Plan (PWM_BITS=8, REPEAT=1 unless stated):
- Hold reset=0 for 3 clocks, then release → all outputs 0 during reset; tready_slave=1 the first cycle after release; pwm_out=0 until the first sample.
- Send 16'h0000 → duty 128; pwm_out high exactly 128 of each 256 clocks; active=1 from t+2.
- Send 16'h8000, then 16'h7FFF → period of 256 low clocks, then 255 high + 1 low.
- Single sample, no further tvalid → underrun pulses exactly 1 cycle every 256 clocks; duty unchanged; REPEAT=4 gives a pulse every 1024 clocks.
- tvalid_slave held high with an incrementing ramp → exactly one transfer per 256 clocks (REPEAT=4: 1024); no underrun; no sample dropped or duplicated.
- NOISE_SHAPE_EN, repeated 16'h0080 → duty alternates 128,129,128,...; 16'h7FFF repeated → saturates, stays 255.

Source files
------------

// File: rtl/sv_audio_pkg.sv
// Shared constants and types for the audio PWM output path.
package sv_audio_pkg;

  localparam int SAMPLE_W = 16;
  localparam logic [SAMPLE_W-1:0] OFFSET_BIN = 16'h8000;

  localparam int PWM_BITS_MIN = 4;
  localparam int PWM_BITS_MAX = 12;
  localparam int REPEAT_MIN   = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pwm_state_e;

  // Signed two's-complement to offset-binary.
  function automatic logic [SAMPLE_W-1:0] to_offset(input logic [SAMPLE_W-1:0] s);
    return s ^ OFFSET_BIN;
  endfunction

endpackage

// File: rtl/pwm_audio_out_quantizer.sv
// Sample-to-duty conversion: plain truncation, or first-order error feedback
// with saturation when NOISE_SHAPE_EN is defined.
module pwm_duty_quantizer
  import sv_audio_pkg::*;
#(
  parameter int PWM_BITS = 8,
  localparam int RES_W   = SAMPLE_W - PWM_BITS
) (
  input  logic [SAMPLE_W-1:0] sample_i,
`ifdef NOISE_SHAPE_EN
  input  logic [RES_W-1:0]    residue_i,
  output logic [RES_W-1:0]    residue_o,
`endif
  output logic [PWM_BITS-1:0] duty_o
);

  logic [SAMPLE_W-1:0] offset;

  assign offset = to_offset(sample_i);

`ifdef NOISE_SHAPE_EN
  logic [SAMPLE_W:0]   sum;
  logic [SAMPLE_W-1:0] sat;

  assign sum       = {1'b0, offset} + {{(SAMPLE_W + 1 - RES_W){1'b0}}, residue_i};
  // Carry out means the feedback pushed past full scale; clamp to max.
  assign sat       = sum[SAMPLE_W] ? '1 : sum[SAMPLE_W-1:0];
  assign duty_o    = sat[SAMPLE_W-1 -: PWM_BITS];
  assign residue_o = sat[RES_W-1:0];
`else
  logic unused_lsbs;

  assign duty_o      = offset[SAMPLE_W-1 -: PWM_BITS];
  assign unused_lsbs = ^offset[RES_W-1:0];
`endif

endmodule

// File: rtl/pwm_audio_out.sv
// PWM audio sink: single-entry sample buffer feeding a frame-based PWM generator.
// Optional noise shaping of the duty via macro NOISE_SHAPE_EN.
//
// state   | meaning
// IDLE    | no sample played yet; output low, counters held at 0
// RUN     | PWM running; new duty taken only at frame boundaries
module pwm_audio_out
  import sv_audio_pkg::*;
#(
  parameter int PWM_BITS = 8,
  parameter int REPEAT   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tvalid_slave,
  output logic                tready_slave,
  input  logic [SAMPLE_W-1:0] tdata_slave,
  output logic                pwm_out,
  output logic                underrun,
  output logic                active
);

  localparam int REP_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [REP_W-1:0]    REP_MAX = REP_W'(REPEAT - 1);
  localparam logic [PWM_BITS-1:0] PER_MAX = '1;

  pwm_state_e          state_q, state_d;
  logic                tready_q;
  logic                pend_valid_q, pend_valid_d;
  logic [SAMPLE_W-1:0] pend_data_q, pend_data_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] per_cnt_q, per_cnt_d;
  logic [REP_W-1:0]    rep_cnt_q, rep_cnt_d;
  logic [PWM_BITS-1:0] q_duty;
  logic                xfer;
  logic                boundary;
  logic                load;

`ifdef NOISE_SHAPE_EN
  localparam int RES_W = SAMPLE_W - PWM_BITS;
  logic [RES_W-1:0] residue_q, residue_d;
  logic [RES_W-1:0] q_residue;
`endif

  pwm_duty_quantizer #(
    .PWM_BITS (PWM_BITS)
  ) u_quant (
    .sample_i  (pend_data_q),
`ifdef NOISE_SHAPE_EN
    .residue_i (residue_q),
    .residue_o (q_residue),
`endif
    .duty_o    (q_duty)
  );

  assign xfer         = tvalid_slave & tready_q;
  assign boundary     = (per_cnt_q == PER_MAX) && (rep_cnt_q == REP_MAX);
  assign tready_slave = tready_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      tready_q     <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      duty_q       <= '0;
      per_cnt_q    <= '0;
      rep_cnt_q    <= '0;
`ifdef NOISE_SHAPE_EN
      residue_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      tready_q     <= ~pend_valid_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      duty_q       <= duty_d;
      per_cnt_q    <= per_cnt_d;
      rep_cnt_q    <= rep_cnt_d;
`ifdef NOISE_SHAPE_EN
      residue_q    <= residue_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    per_cnt_d = per_cnt_q;
    rep_cnt_d = rep_cnt_q;
    load      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        per_cnt_d = '0;
        rep_cnt_d = '0;
        if (pend_valid_q) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        per_cnt_d = per_cnt_q + 1'b1;
        if (per_cnt_q == PER_MAX) begin
          rep_cnt_d = (rep_cnt_q == REP_MAX) ? '0 : rep_cnt_q + 1'b1;
        end
        // Without a pending sample the current duty simply plays again.
        if (boundary && pend_valid_q) begin
          load = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    duty_d       = duty_q;
`ifdef NOISE_SHAPE_EN
    residue_d    = residue_q;
`endif
    if (load) begin
      pend_valid_d = 1'b0;
      duty_d       = q_duty;
`ifdef NOISE_SHAPE_EN
      residue_d    = q_residue;
`endif
    end
    // tready is low while a sample is pending, so this never overlaps a load.
    if (xfer) begin
      pend_valid_d = 1'b1;
      pend_data_d  = tdata_slave;
    end
  end

  always_comb begin
    active   = (state_q == ST_RUN);
    pwm_out  = active && (per_cnt_q < duty_q);
    underrun = active && boundary && !pend_valid_q;
  end

endmodule

// File: tb/tb_pwm_audio_out.sv
// Directed bench for pwm_audio_out: REPEAT=1 and REPEAT=4 instances, PWM_BITS=8.
// Noise-shaping expectations follow NOISE_SHAPE_EN when it is defined.
module tb_pwm_audio_out;

  logic        clk = 1'b0;
  logic        reset;
  logic        tv1, tr1, pwm1, un1, act1;
  logic        tv4, tr4, pwm4, un4, act4;
  logic [15:0] td1, td4;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pwm_audio_out #(.PWM_BITS(8), .REPEAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .tvalid_slave(tv1), .tready_slave(tr1),
    .tdata_slave(td1), .pwm_out(pwm1), .underrun(un1), .active(act1)
  );

  pwm_audio_out #(.PWM_BITS(8), .REPEAT(4)) u_dut4 (
    .clk(clk), .reset(reset), .tvalid_slave(tv4), .tready_slave(tr4),
    .tdata_slave(td4), .pwm_out(pwm4), .underrun(un4), .active(act4)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    tv1   = 1'b0;
    tv4   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tready", int'(tr1), 0);
    chk("rst_pwm", int'(pwm1), 0);
    chk("rst_underrun", int'(un1), 0);
    chk("rst_active", int'(act1 | act4), 0);
    reset = 1'b1;
  endtask

  // Returns at the negedge of the cycle following the transfer.
  task automatic send(input bit sel4, input logic [15:0] d);
    int k = 0;
    @(negedge clk);
    if (sel4) begin tv4 = 1'b1; td4 = d; end
    else      begin tv1 = 1'b1; td1 = d; end
    while (!(sel4 ? tr4 : tr1) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("send_accept", int'(k < 3000), 1);
    @(negedge clk);
    tv1 = 1'b0;
    tv4 = 1'b0;
    chk("tready_drop", int'(sel4 ? tr4 : tr1), 0);
  endtask

  task automatic measure(input bit sel4, input int n, output int hi, output int un,
                         output int first_un, output int act0);
    logic p, u, a;
    hi = 0; un = 0; first_un = -1; act0 = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      p = sel4 ? pwm4 : pwm1;
      u = sel4 ? un4 : un1;
      a = sel4 ? act4 : act1;
      if (i == 0) act0 = int'(a);
      hi += int'(p);
      un += int'(u);
      if (u && first_un < 0) first_un = i;
    end
  endtask

  // Call right after do_reset: tvalid held high, data stepped after each transfer.
  task automatic stream(input bit sel4, input logic [15:0] start, input logic [15:0] step,
                        output int nx, output int un, output int hi, output int h0, output int h1);
    int  fl = sel4 ? 1024 : 256;
    int  n  = 2 + 8 * fl;
    bit  xf = 1'b0;
    logic p;
    nx = 0; un = 0; hi = 0; h0 = 0; h1 = 0;
    if (sel4) begin tv4 = 1'b1; td4 = start; end
    else      begin tv1 = 1'b1; td1 = start; end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (xf) begin
        if (sel4) td4 = td4 + step;
        else      td1 = td1 + step;
      end
      xf = sel4 ? tr4 : tr1;
      nx += int'(xf);
      un += int'(sel4 ? un4 : un1);
      p  = sel4 ? pwm4 : pwm1;
      hi += int'(p);
      if (i >= 2 && i < 2 + fl)          h0 += int'(p);
      if (i >= 2 + fl && i < 2 + 2 * fl) h1 += int'(p);
    end
    tv1 = 1'b0;
    tv4 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, un, fu, a0, nx, h0, h1;
    reset = 1'b0;
    tv1 = 1'b0; tv4 = 1'b0;
    td1 = '0;   td4 = '0;

    do_reset();
    @(negedge clk);
    chk("tready_release", int'(tr1), 1);
    chk("pwm_idle", int'(pwm1), 0);
    chk("active_idle", int'(act1), 0);

    // Mid-scale sample: 50% duty
    send(1'b0, 16'h0000);
    chk("active_t1", int'(act1), 0);
    measure(1'b0, 256, hi, un, fu, a0);
    chk("active_t2", a0, 1);
    chk("mid_high", hi, 128);
    chk("mid_underrun", un, 1);
    chk("mid_underrun_pos", fu, 255);

    // Pending sample discarded by reset mid-frame
    send(1'b0, 16'h7FFF);
    do_reset();
    measure(1'b0, 300, hi, un, fu, a0);
    chk("discard_high", hi, 0);
    chk("discard_active", int'(act1), 0);

    // Minimum then maximum duty
    do_reset();
    send(1'b0, 16'h8000);
    send(1'b0, 16'h7FFF);
    measure(1'b0, 254, hi, un, fu, a0);
    chk("min_high", hi, 0);
    chk("min_underrun", un, 0);
    measure(1'b0, 256, hi, un, fu, a0);
    chk("max_high", hi, 255);
    chk("max_underrun", un, 1);
    chk("max_underrun_pos", fu, 255);

    // Starved: last duty repeats, one underrun per frame
    measure(1'b0, 512, hi, un, fu, a0);
    chk("starve_high", hi, 510);
    chk("starve_underrun", un, 2);

    // Ramp, REPEAT=1
    do_reset();
    stream(1'b0, 16'h8A00, 16'h0100, nx, un, hi, h0, h1);
    chk("ramp1_xfers", nx, 9);
    chk("ramp1_underrun", un, 0);
    chk("ramp1_high", hi, 108);
    chk("ramp1_f0", h0, 10);
    chk("ramp1_f1", h1, 11);

    // REPEAT=4 underrun spacing
    do_reset();
    send(1'b1, 16'hC000);
    measure(1'b1, 2048, hi, un, fu, a0);
    chk("r4_active", a0, 1);
    chk("r4_high", hi, 512);
    chk("r4_underrun", un, 2);
    chk("r4_underrun_pos", fu, 1023);

    // Ramp, REPEAT=4
    do_reset();
    stream(1'b1, 16'h8A00, 16'h0100, nx, un, hi, h0, h1);
    chk("ramp4_xfers", nx, 9);
    chk("ramp4_underrun", un, 0);
    chk("ramp4_high", hi, 432);
    chk("ramp4_f0", h0, 40);
    chk("ramp4_f1", h1, 44);

    // Small repeated sample: residue dithers the LSB when noise shaping is on
    do_reset();
    stream(1'b0, 16'h0080, 16'h0000, nx, un, hi, h0, h1);
    chk("ns_xfers", nx, 9);
`ifdef NOISE_SHAPE_EN
    chk("ns_f0", h0, 128);
    chk("ns_f1", h1, 129);
    chk("ns_high", hi, 1028);
`else
    chk("ns_f0", h0, 128);
    chk("ns_f1", h1, 128);
    chk("ns_high", hi, 1024);
`endif

    // Full-scale repeated sample saturates
    do_reset();
    stream(1'b0, 16'h7FFF, 16'h0000, nx, un, hi, h0, h1);
    chk("sat_f0", h0, 255);
    chk("sat_f1", h1, 255);
    chk("sat_high", hi, 2040);
    chk("sat_underrun", un, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
